mfsk_demodulator: RTL and testbench

MFSK_DEMODULATOR -- requirements
Module: mfsk_demodulator

---
 rtl/mfsk_demodulator.sv | 238 +++++++++++++++++++++++
 tb/tb_mfsk_demodulator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mfsk_demodulator.sv
// MFSK demodulator: counts hysteresis zero crossings over a fixed window of valid
// samples, decides the tone index and serialises the symbol MSB first.
module mfsk_demodulator #(
  parameter int ADC_W   = 14,
  parameter int SYM_LEN = 1024,
  parameter int HYST    = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ADC_W-1:0] adc_in,
  input  logic                    sample_valid,
  input  logic                    enable,
  input  logic [1:0]              mode,
  output logic [3:0]              sym_data,
  output logic                    sym_valid,
  output logic                    data_out,
  output logic                    bit_valid,
  output logic                    overrange,
  output logic                    no_signal
);

  localparam int CNT_W = $clog2(SYM_LEN);
  localparam int C_W   = CNT_W + 1;
  localparam int RAW_W = C_W - 1;

  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(SYM_LEN - 1);
  localparam logic signed [ADC_W-1:0] HYST_HI  = ADC_W'(HYST);
  localparam logic signed [ADC_W-1:0] HYST_LO  = ADC_W'(-HYST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_DECIDE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    H_UNK = 2'd0,
    H_POS = 2'd1,
    H_NEG = 2'd2
  } hyst_t;

  // Values strictly inside the band keep the previous polarity.
  function automatic hyst_t hyst_step(input hyst_t cur, input logic signed [ADC_W-1:0] x);
    if (x >= HYST_HI) begin
      return H_POS;
    end else if (x <= HYST_LO) begin
      return H_NEG;
    end else begin
      return cur;
    end
  endfunction

  state_t           state_r;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] cnt_r;
  logic [C_W-1:0]   cross_r;
  hyst_t            hyst_r;
  logic [3:0]       sym_data_r;
  logic             sym_valid_r;
  logic             overrange_r;
  logic             no_signal_r;
  logic             data_out_r;
  logic             bit_valid_r;
  logic [3:0]       ser_sym_r;
  logic [1:0]       ser_idx_r;

  hyst_t            base_hyst_s;
  logic [C_W-1:0]   base_cross_s;
  logic [CNT_W-1:0] base_cnt_s;
  hyst_t            upd_hyst_s;
  logic [C_W-1:0]   upd_cross_s;
  logic [CNT_W-1:0] upd_cnt_s;
  logic             crossing_s;
  logic             last_s;
  logic             dec_fire_s;
  logic [3:0]       m_max_s;
  logic [RAW_W-1:0] raw_s;
  logic [3:0]       dec_sym_s;
  logic             dec_ovr_s;
  logic             dec_nosig_s;
  logic [1:0]       ser_next_idx_s;

  // Window accumulators after applying this cycle's sample; a new window starts from scratch.
  always_comb begin
    base_hyst_s  = H_UNK;
    base_cross_s = '0;
    base_cnt_s   = '0;
    if (state_r == S_ACQ) begin
      base_hyst_s  = hyst_r;
      base_cross_s = cross_r;
      base_cnt_s   = cnt_r;
    end else begin
      base_hyst_s  = H_UNK;
      base_cross_s = '0;
      base_cnt_s   = '0;
    end

    upd_hyst_s  = base_hyst_s;
    upd_cross_s = base_cross_s;
    upd_cnt_s   = base_cnt_s;
    crossing_s  = 1'b0;
    if (sample_valid) begin
      upd_hyst_s = hyst_step(base_hyst_s, adc_in);
      upd_cnt_s  = base_cnt_s + CNT_W'(1);
      crossing_s = ((base_hyst_s == H_POS) && (upd_hyst_s == H_NEG)) ||
                   ((base_hyst_s == H_NEG) && (upd_hyst_s == H_POS));
      if (crossing_s && (base_cross_s != {C_W{1'b1}})) begin
        upd_cross_s = base_cross_s + C_W'(1);
      end else begin
        upd_cross_s = base_cross_s;
      end
    end else begin
      upd_hyst_s  = base_hyst_s;
      upd_cross_s = base_cross_s;
      upd_cnt_s   = base_cnt_s;
    end

    last_s     = (state_r == S_ACQ) && sample_valid && (cnt_r == LAST_IDX);
    dec_fire_s = last_s && enable;
  end

  // Symbol decision from the crossing count including the final sample.
  always_comb begin
    case (mode_r)
      2'b00:   m_max_s = 4'd1;
      2'b01:   m_max_s = 4'd3;
      2'b10:   m_max_s = 4'd7;
      default: m_max_s = 4'd15;
    endcase
    raw_s       = upd_cross_s[C_W-1:1];
    dec_sym_s   = 4'd0;
    dec_ovr_s   = 1'b0;
    dec_nosig_s = 1'b0;
    if (upd_hyst_s == H_UNK) begin
      dec_sym_s   = 4'd0;
      dec_ovr_s   = 1'b0;
      dec_nosig_s = 1'b1;
    end else if (raw_s > RAW_W'(m_max_s)) begin
      dec_sym_s = m_max_s;
      dec_ovr_s = 1'b1;
    end else begin
      dec_sym_s = raw_s[3:0];
      dec_ovr_s = 1'b0;
    end
    ser_next_idx_s = ser_idx_r - 2'd1;
  end

  // Window control FSM and registered decision outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      mode_r      <= 2'd0;
      cnt_r       <= '0;
      cross_r     <= '0;
      hyst_r      <= H_UNK;
      sym_data_r  <= 4'd0;
      sym_valid_r <= 1'b0;
      overrange_r <= 1'b0;
      no_signal_r <= 1'b0;
    end else begin
      sym_valid_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DECIDE: begin
          if (enable) begin
            state_r <= S_ACQ;
            mode_r  <= mode;
            cnt_r   <= upd_cnt_s;
            cross_r <= upd_cross_s;
            hyst_r  <= upd_hyst_s;
          end else begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            cross_r <= '0;
            hyst_r  <= H_UNK;
          end
        end
        S_ACQ: begin
          if (!enable) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            cross_r <= '0;
            hyst_r  <= H_UNK;
          end else if (last_s) begin
            state_r     <= S_DECIDE;
            cnt_r       <= '0;
            cross_r     <= '0;
            hyst_r      <= H_UNK;
            sym_data_r  <= dec_sym_s;
            overrange_r <= dec_ovr_s;
            no_signal_r <= dec_nosig_s;
            sym_valid_r <= 1'b1;
          end else begin
            cnt_r   <= upd_cnt_s;
            cross_r <= upd_cross_s;
            hyst_r  <= upd_hyst_s;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= '0;
          cross_r <= '0;
          hyst_r  <= H_UNK;
        end
      endcase
    end
  end

  // Serialiser: runs to completion independent of enable; index mode_r equals B-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_valid_r <= 1'b0;
      data_out_r  <= 1'b0;
      ser_sym_r   <= 4'd0;
      ser_idx_r   <= 2'd0;
    end else if (dec_fire_s) begin
      bit_valid_r <= 1'b1;
      data_out_r  <= dec_sym_s[mode_r];
      ser_sym_r   <= dec_sym_s;
      ser_idx_r   <= mode_r;
    end else if (bit_valid_r && (ser_idx_r != 2'd0)) begin
      bit_valid_r <= 1'b1;
      data_out_r  <= ser_sym_r[ser_next_idx_s];
      ser_idx_r   <= ser_next_idx_s;
    end else begin
      bit_valid_r <= 1'b0;
      data_out_r  <= 1'b0;
      ser_idx_r   <= 2'd0;
    end
  end

  assign sym_data  = sym_data_r;
  assign sym_valid = sym_valid_r;
  assign overrange = overrange_r;
  assign no_signal = no_signal_r;
  assign data_out  = data_out_r;
  assign bit_valid = bit_valid_r;

endmodule

// File: tb/tb_mfsk_demodulator.sv
// Scoreboard bench for mfsk_demodulator: a window-level reference model predicts each
// decision and bit burst; a monitor compares whenever sym_valid is seen.
module tb_mfsk_demodulator;

  localparam int ADC_W   = 14;
  localparam int SYM_LEN = 1024;
  localparam int HYST    = 256;
  localparam int CMAX    = (1 << ($clog2(SYM_LEN) + 1)) - 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic signed [ADC_W-1:0] adc_in;
  logic                    sample_valid;
  logic                    enable;
  logic [1:0]              mode;
  logic [3:0]              sym_data;
  logic                    sym_valid;
  logic                    data_out;
  logic                    bit_valid;
  logic                    overrange;
  logic                    no_signal;

  always #5 clk = ~clk;

  mfsk_demodulator #(.ADC_W(ADC_W), .SYM_LEN(SYM_LEN), .HYST(HYST)) dut (
    .clk(clk), .reset(reset), .adc_in(adc_in), .sample_valid(sample_valid),
    .enable(enable), .mode(mode), .sym_data(sym_data), .sym_valid(sym_valid),
    .data_out(data_out), .bit_valid(bit_valid), .overrange(overrange),
    .no_signal(no_signal)
  );

  typedef struct {
    logic [3:0] sym;
    logic       ovr;
    logic       nosig;
    int         nbits;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   idle_err = 0;

  bit         win_active = 1'b0;
  bit         just_decided = 1'b0;
  logic [1:0] win_mode = 2'd0;
  int         win_s[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Polarity of decisive samples only; a crossing is a change of that polarity.
  function automatic exp_t predict(input int s[$], input logic [1:0] md);
    exp_t e;
    int pol = 0;
    int p;
    int trans = 0;
    int raw;
    int mmax;
    foreach (s[i]) begin
      if (s[i] >= HYST) p = 1;
      else if (s[i] <= -HYST) p = -1;
      else p = 0;
      if (p != 0) begin
        if (pol != 0 && p != pol) trans++;
        pol = p;
      end
    end
    if (trans > CMAX) trans = CMAX;
    mmax = (1 << (int'(md) + 1)) - 1;
    raw = trans / 2;
    e.nbits = int'(md) + 1;
    e.cyc = 0;
    if (pol == 0) begin
      e.sym = 4'd0; e.ovr = 1'b0; e.nosig = 1'b1;
    end else if (raw > mmax) begin
      e.sym = 4'(mmax); e.ovr = 1'b1; e.nosig = 1'b0;
    end else begin
      e.sym = 4'(raw); e.ovr = 1'b0; e.nosig = 1'b0;
    end
    return e;
  endfunction

  function automatic int tone(input int k, input int n, input real ph, input int namp);
    real v;
    int noise;
    v = 8000.0 * $sin(6.283185307179586 * k * n / SYM_LEN + ph);
    noise = (namp > 0) ? (int'($urandom_range(2 * namp, 0)) - namp) : 0;
    return $rtoi(v) + noise;
  endfunction

  // One clock of stimulus plus the window bookkeeping of the reference model.
  task automatic drive(input int x, input bit v, input bit en, input logic [1:0] md);
    exp_t e;
    @(posedge clk); #1;
    adc_in = ADC_W'(x);
    sample_valid = v;
    enable = en;
    mode = md;
    if (!en) begin
      win_active = 1'b0;
      just_decided = 1'b0;
      win_s.delete();
    end else begin
      if (!win_active || just_decided) begin
        win_active = 1'b1;
        win_mode = md;
        win_s.delete();
      end
      just_decided = 1'b0;
      if (v) begin
        win_s.push_back(x);
        if (win_s.size() == SYM_LEN) begin
          e = predict(win_s, win_mode);
          e.cyc = cyc + 1;
          sb_q.push_back(e);
          just_decided = 1'b1;
        end
      end
    end
  endtask

  // gap: 0 = gapless, 1 = strict 1/0 alternation, 2 = random gaps
  task automatic run_window(input int k, input logic [1:0] md0, input logic [1:0] md1,
                            input int sw_n, input real ph, input int gap);
    logic [1:0] md;
    for (int n = 0; n < SYM_LEN; n++) begin
      md = (n >= sw_n) ? md1 : md0;
      if (gap == 1) begin
        drive(int'($urandom_range(16000, 0)) - 8000, 1'b0, 1'b1, md);
      end else if (gap == 2) begin
        while ($urandom_range(99, 0) < 30) drive(int'($urandom_range(16000, 0)) - 8000, 1'b0, 1'b1, md);
      end
      drive(tone(k, n, ph, 40), 1'b1, 1'b1, md);
    end
  endtask

  task automatic run_partial(input int k, input logic [1:0] md, input int count);
    for (int n = 0; n < count; n++) drive(tone(k, n, 0.0, 40), 1'b1, 1'b1, md);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sym_data"}, sym_data, 0);
    check({tag, "_sym_valid"}, sym_valid, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_bit_valid"}, bit_valid, 0);
    check({tag, "_overrange"}, overrange, 0);
    check({tag, "_no_signal"}, no_signal, 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    enable = 1'b0;
    sample_valid = 1'b0;
    win_active = 1'b0;
    just_decided = 1'b0;
    win_s.delete();
    #2;
    check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Monitor: pops one expectation per sym_valid and follows the bit burst.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sym_valid) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_sym_valid: got sym_data=%0d with no decision expected (t=%0t)", sym_data, $time);
        end else begin
          e = sb_q.pop_front();
          check("sym_data", sym_data, e.sym);
          check("overrange", overrange, e.ovr);
          check("no_signal", no_signal, e.nosig);
          check("sym_valid_cycle", cyc, e.cyc);
          for (int i = 0; i < e.nbits; i++) begin
            if (i > 0) @(negedge clk);
            check("bit_valid", bit_valid, 1);
            check("data_out", data_out, e.sym[e.nbits - 1 - i]);
          end
          @(negedge clk);
          check("bit_valid_end", bit_valid, 0);
          if (sym_valid) idle_err++;
        end
      end else if (bit_valid || data_out) begin
        idle_err++;
      end
    end
  end

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    sample_valid = 1'b0;
    adc_in = '0;
    mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(posedge clk); #1 reset = 1'b1;

    // 2-FSK: one and two cycles per window
    run_window(1, 2'd0, 2'd0, SYM_LEN, 0.0, 0);
    run_window(2, 2'd0, 2'd0, SYM_LEN, 0.0, 0);

    // 16-FSK sweep, then one tone above the alphabet
    for (int k = 0; k < 16; k++) run_window(k + 1, 2'd3, 2'd3, SYM_LEN, 0.0, 0);
    run_window(17, 2'd3, 2'd3, SYM_LEN, 0.0, 0);

    // constant inside the hysteresis band
    for (int n = 0; n < SYM_LEN; n++) drive(100, 1'b1, 1'b1, 2'd0);

    // alternating sample_valid
    run_window(2, 2'd0, 2'd0, SYM_LEN, 0.0, 1);

    // reset mid-window, then a full window
    run_partial(3, 2'd1, 500);
    apply_reset();
    run_window(3, 2'd1, 2'd1, SYM_LEN, 0.0, 0);

    // enable dropped mid-window, then a full window
    run_partial(2, 2'd0, 500);
    repeat (5) drive(0, 1'b0, 1'b0, 2'd0);
    run_window(2, 2'd0, 2'd0, SYM_LEN, 0.0, 0);

    // mode change mid-window applies from the following window
    run_window(5, 2'd0, 2'd2, 300, 0.0, 0);
    run_window(5, 2'd2, 2'd2, SYM_LEN, 0.0, 0);

    // randomized windows
    for (int w = 0; w < 6; w++) begin
      run_window(int'($urandom_range(20, 1)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                 int'($urandom_range(SYM_LEN - 1, 0)),
                 real'($urandom_range(628, 0)) / 100.0, 2);
    end

    repeat (20) drive(0, 1'b0, 1'b0, 2'd0);
    check("pending_decisions", sb_q.size(), 0);
    check("stray_serial_activity", idle_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
